// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl
//   Write-side controller of a dual-clock FIFO. Converts user push requests
//   into RAM write strobes and addresses. Keeps the binary and Gray write
//   pointers and brings the read-domain Gray pointer into wr_clk through a
//   flop chain. Produces registered full, almost-full, occupancy and a sticky
//   overflow flag.
//
// Handshake: a push is accepted at a wr_clk edge when wr_req = 1 and full = 0
//   at that edge (full acts as the inverse of ready). ram_wr_en is the
//   accepted-push strobe; there is no back-pressure on the RAM side.
//
// Ports
//   wr_clk, rst_n      write clock, synchronous active-low reset
//   wr_req             push request
//   ovf_clr            clears the sticky overflow flag (wins over a new overflow)
//   rd_ptr_gray        read pointer in Gray code, asynchronous to wr_clk
//   ram_wr_en          RAM write enable (combinational, 0 while in reset)
//   ram_wr_addr        RAM write address
//   wr_ptr_gray        registered Gray write pointer for the read domain
//   full, almost_full  registered status flags
//   wr_count           registered occupancy as seen from the write side
//   overflow           sticky: wr_req seen while full
module async_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH         = 4,
  parameter int SYNC_STAGES        = 2,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input  logic                  wr_clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic                  ovf_clr,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow
);

  localparam int AW    = ADDR_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [AW:0] AF_THRESH = ALMOST_FULL_THRESH[AW:0];

  if (ADDR_WIDTH < 1) begin : g_chk_aw
    $error("async_fifo_wr_ctrl: ADDR_WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("async_fifo_wr_ctrl: SYNC_STAGES must be >= 2");
  end
  if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > DEPTH) begin : g_chk_af
    $error("async_fifo_wr_ctrl: ALMOST_FULL_THRESH must be in 1..DEPTH");
  end

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [AW:0] wr_bin_q,  wr_bin_d;
  logic [AW:0] wr_gray_q, wr_gray_d;
  logic [AW:0] rq_q [SYNC_STAGES];
  logic [AW:0] rq_d [SYNC_STAGES];
  logic        full_q,        full_d;
  logic        almost_full_q, almost_full_d;
  logic [AW:0] count_q,       count_d;
  logic        overflow_q,    overflow_d;

  logic        push;
  logic [AW:0] rq_sync;
  logic [AW:0] rd_bin_sync;
  logic [AW:0] full_mask;

  always_comb begin
    // Synchronizer: pure flop-to-flop chain, nothing between stages.
    rq_d[0] = rd_ptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      rq_d[i] = rq_q[i-1];
    end
  end

  always_comb begin
    push        = wr_req & ~full_q & rst_n;
    wr_bin_d    = wr_bin_q + {{AW{1'b0}}, push};
    wr_gray_d   = wr_bin_d ^ (wr_bin_d >> 1);
    rq_sync     = rq_q[SYNC_STAGES-1];
    rd_bin_sync = gray2bin(rq_sync);

    // Full when the write pointer is exactly one lap ahead: in Gray code that
    // is the read pointer with its top two bits inverted (both bits when
    // ADDR_WIDTH = 1).
    full_mask         = '0;
    full_mask[AW]     = 1'b1;
    full_mask[AW-1]   = 1'b1;
    full_d            = (wr_gray_d == (rq_sync ^ full_mask));

    // Using the post-push pointer gives zero added latency for our own pushes.
    count_d       = wr_bin_d - rd_bin_sync;
    almost_full_d = (count_d >= AF_THRESH);

    overflow_d = ovf_clr ? 1'b0 : (overflow_q | (wr_req & full_q));
  end

  always_ff @(posedge wr_clk) begin
    if (!rst_n) begin
      wr_bin_q      <= '0;
      wr_gray_q     <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rq_q[i] <= '0;
      end
    end else begin
      wr_bin_q      <= wr_bin_d;
      wr_gray_q     <= wr_gray_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rq_q[i] <= rq_d[i];
      end
    end
  end

  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_bin_q[AW-1:0];
  assign wr_ptr_gray = wr_gray_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_count    = count_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Testbench for async_fifo_wr_ctrl: default-parameter instance driven by a
// model-backed scoreboard, plus a small ADDR_WIDTH = 1 instance.
module tb_async_fifo_wr_ctrl;

  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;          // posedges at 5,15,25,...
  initial begin                        // rd rising edges at 3,28,53,... (never near wr edges)
    #3;
    forever begin
      rd_clk = 1'b1; #12;
      rd_clk = 1'b0; #13;
    end
  end

  logic       rst_n = 1'b0;
  logic       wr_req = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [4:0] rd_ptr_gray;
  logic       ram_wr_en;
  logic [3:0] ram_wr_addr;
  logic [4:0] wr_ptr_gray;
  logic       full, almost_full, overflow;
  logic [4:0] wr_count;

  logic       rst2_n = 1'b0;
  logic       wr_req2 = 1'b0;
  logic       ovf_clr2 = 1'b0;
  logic [1:0] rd_ptr_gray2 = 2'b00;
  logic       ram_wr_en2;
  logic [0:0] ram_wr_addr2;
  logic [1:0] wr_ptr_gray2;
  logic       full2, almost_full2, overflow2;
  logic [1:0] wr_count2;

  async_fifo_wr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(2), .ALMOST_FULL_THRESH(12)) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .wr_req(wr_req), .ovf_clr(ovf_clr),
    .rd_ptr_gray(rd_ptr_gray), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .wr_ptr_gray(wr_ptr_gray), .full(full), .almost_full(almost_full),
    .wr_count(wr_count), .overflow(overflow)
  );

  async_fifo_wr_ctrl #(.ADDR_WIDTH(1), .SYNC_STAGES(2), .ALMOST_FULL_THRESH(2)) dut2 (
    .wr_clk(wr_clk), .rst_n(rst2_n), .wr_req(wr_req2), .ovf_clr(ovf_clr2),
    .rd_ptr_gray(rd_ptr_gray2), .ram_wr_en(ram_wr_en2), .ram_wr_addr(ram_wr_addr2),
    .wr_ptr_gray(wr_ptr_gray2), .full(full2), .almost_full(almost_full2),
    .wr_count(wr_count2), .overflow(overflow2)
  );

  // ---------------- reference model state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int m_wr    = 0;        // pushes accepted since reset (true count)
  int rd_cnt  = 0;        // reads performed since reset (true count)
  logic m_full = 1'b0;
  logic m_ovf  = 1'b0;
  int phase_pushes = 0;
  logic rd_en = 1'b0;
  int hist[$];            // read count present at each wr_clk edge since reset

  logic [3:0]  exp_wr_q[$];   // expected write addresses
  logic [12:0] exp_st_q[$];   // {full, almost_full, count[4:0], gray[4:0], overflow}

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  assign rd_ptr_gray = gray5(rd_cnt);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read side on its own clock: advance only while the FIFO truly holds data.
  initial begin
    forever begin
      @(posedge rd_clk);
      if (rd_en && rd_cnt < m_wr && $urandom_range(0, 1) == 1) rd_cnt = rd_cnt + 1;
    end
  end

  // Record which read count the synchronizer sees at each write edge.
  always @(posedge wr_clk) begin
    if (!rst_n) hist.delete();
    else        hist.push_back(rd_cnt);
  end

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic req, input logic clr, input logic rst);
    int   j, rdv, occ;
    logic ovf_n;
    @(negedge wr_clk);
    wr_req  = req;
    ovf_clr = clr;
    rst_n   = ~rst;
    if (rst) begin
      m_wr   = 0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
      exp_st_q.push_back(13'd0);
    end else begin
      ovf_n = clr ? 1'b0 : (m_ovf | (req & m_full));
      if (req && !m_full) begin
        exp_wr_q.push_back(4'(m_wr % DEPTH));
        m_wr = m_wr + 1;
        phase_pushes++;
      end
      // A read count seen at edge k reaches the flags at edge k+2.
      j   = hist.size();
      rdv = (j >= 2) ? hist[j-2] : 0;
      occ = m_wr - rdv;
      m_full = (occ == DEPTH);
      m_ovf  = ovf_n;
      exp_st_q.push_back({m_full, (occ >= 12), 5'(occ), gray5(m_wr), m_ovf});
    end
  endtask

  // ---------------- monitors / scoreboard ----------------
  always @(negedge wr_clk) begin
    #2;
    if (ram_wr_en === 1'b1) begin
      n_tests++;
      if (exp_wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr %0h, no write expected at %0t", ram_wr_addr, $time);
      end else begin
        check("wr_addr", 32'(ram_wr_addr), 32'(exp_wr_q.pop_front()));
        n_tests--;  // check() already counted this comparison
      end
    end
  end

  always @(posedge wr_clk) begin
    logic [12:0] e;
    #1;
    if (exp_st_q.size() > 0) begin
      e = exp_st_q.pop_front();
      check("full",        32'(full),        32'(e[12]));
      check("almost_full", 32'(almost_full), 32'(e[11]));
      check("wr_count",    32'(wr_count),    32'(e[10:6]));
      check("wr_ptr_gray", 32'(wr_ptr_gray), 32'(e[5:1]));
      check("overflow",    32'(overflow),    32'(e[0]));
      n_tests++;
      if (wr_count > 5'd16) begin
        n_fail++;
        $display("FAIL count_range: got %0d required <= 16", wr_count);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int cyc;

    // ADDR_WIDTH = 1, threshold 2: full and almost_full together after 2 pushes.
    @(negedge wr_clk);
    @(negedge wr_clk);
    rst2_n  = 1'b1;
    wr_req2 = 1'b1;
    @(posedge wr_clk); #1;
    check("aw1_full_1",  32'(full2),        32'd0);
    check("aw1_af_1",    32'(almost_full2), 32'd0);
    check("aw1_count_1", 32'(wr_count2),    32'd1);
    @(posedge wr_clk); #1;
    check("aw1_full_2",  32'(full2),        32'd1);
    check("aw1_af_2",    32'(almost_full2), 32'd1);
    check("aw1_count_2", 32'(wr_count2),    32'd2);
    @(negedge wr_clk); #2;
    check("aw1_blocked", 32'(ram_wr_en2),   32'd0);
    @(posedge wr_clk); #1;
    check("aw1_ovf",     32'(overflow2),    32'd1);
    check("aw1_gray",    32'(wr_ptr_gray2), 32'd3);
    check("aw1_addr",    32'(ram_wr_addr2), 32'd0);
    wr_req2 = 1'b0;

    // Reset, then fill: 16 pushes with the read pointer parked at 0.
    drive_cycle(1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b1);
    repeat (16) drive_cycle(1'b1, 1'b0, 1'b0);
    // Requests while full: blocked, overflow sticks, then cleared.
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    // One read: full must fall on the third edge after the change.
    rd_cnt = 1;
    repeat (5) drive_cycle(1'b0, 1'b0, 1'b0);

    // Concurrent random pushes and reads from the unrelated rd_clk.
    rd_en = 1'b1;
    phase_pushes = 0;
    cyc = 0;
    while (phase_pushes < 40 && cyc < 3000) begin
      drive_cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 15) == 0), 1'b0);
      cyc++;
    end
    check("random_phase_done", 32'(phase_pushes >= 40), 32'd1);
    rd_en = 1'b0;
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);

    // Mid-operation reset after 7 pushes; next push must use address 0.
    rd_cnt = 0;
    drive_cycle(1'b0, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b1);
    repeat (7) drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 1'b0);
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge wr_clk);
    #2;
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("st_queue_drained", 32'(exp_st_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/async_fifo_wr_ctrl.md
# async_fifo_wr_ctrl

Write-domain controller for the asynchronous FIFO. It sits directly upstream of the dual-clock storage RAM and drives that RAM's write enable and write address from a user push request. It keeps the binary and Gray write pointers and synchronizes the read-domain Gray pointer into wr_clk. From these it produces registered full, almost-full, occupancy and sticky overflow indications.

## Interface
- ADDR_WIDTH, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH
- SYNC_STAGES, 2, flops in the rd_ptr_gray synchronizer; legal range >= 2
- ALMOST_FULL_THRESH, 12, occupancy at or above which almost_full asserts; legal range 1..DEPTH
- wr_clk  in  1  write clock
- rst_n  in  1  reset, synchronous, active-low, sampled on wr_clk
- wr_req  in  1  user push request
- ovf_clr  in  1  clears sticky overflow
- rd_ptr_gray  in  ADDR_WIDTH+1  read pointer Gray code, launched from a rd_clk register; asynchronous to wr_clk
- ram_wr_en  out  1  RAM write enable
- ram_wr_addr  out  ADDR_WIDTH  RAM write address
- wr_ptr_gray  out  ADDR_WIDTH+1  registered write pointer in Gray code, to the read domain
- full  out  1  registered full flag
- almost_full  out  1  registered, occupancy >= ALMOST_FULL_THRESH
- wr_count  out  ADDR_WIDTH+1  registered occupancy seen from the write side, range 0..DEPTH
- overflow  out  1  sticky, wr_req seen while full

## Operation
- Parameter checks at elaboration: ADDR_WIDTH < 1, SYNC_STAGES < 2, or ALMOST_FULL_THRESH outside 1..DEPTH is an $error.
- push = wr_req & ~full. ram_wr_en = push, combinational.
- ram_wr_addr = wr_bin[ADDR_WIDTH-1:0]. wr_bin is an (ADDR_WIDTH+1)-bit register.
- wr_bin_next = wr_bin + push, modulo 2**(ADDR_WIDTH+1). The extra MSB is the lap bit.
- wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1). wr_ptr_gray is registered from wr_gray_next, so exactly one bit changes per push.
- Synchronizer: a chain of SYNC_STAGES flops. rq[0] captures rd_ptr_gray; rq_sync = rq[SYNC_STAGES-1]. No logic sits between stages.
- rd_bin_sync = Gray-to-binary(rq_sync), computed by MSB-down XOR.
- full <= (wr_gray_next == {~rq_sync[AW:AW-1], rq_sync[AW-2:0]}), where AW = ADDR_WIDTH. For ADDR_WIDTH = 1, both bits are inverted.
- wr_count <= wr_bin_next - rd_bin_sync, modulo 2**(ADDR_WIDTH+1).
- almost_full <= (wr_bin_next - rd_bin_sync) >= ALMOST_FULL_THRESH.
- overflow <= ovf_clr ? 0 : (overflow | (wr_req & full)). When ovf_clr and an overflowing request coincide, ovf_clr wins.
- Reset (rst_n = 0 at a wr_clk edge) clears all state:
  - wr_bin, wr_ptr_gray, every rq stage, full, almost_full, wr_count and overflow all go to 0.
  - While rst_n = 0, ram_wr_en is forced to 0.
- Reset mid-operation discards the write pointer. Clearing the read side at the same time is the integrating FIFO's responsibility.
- full is conservative: it may stay high after reads have occurred, but never drops while the FIFO is actually full. A push is never accepted while full = 1.

## Timing
- A push at edge N writes RAM entry ram_wr_addr at edge N. wr_bin and wr_ptr_gray update at edge N.
- full, almost_full and wr_count reflect that push after edge N, with zero added latency.
- The DEPTH-th push since the last read asserts full at that same edge.
- A change on rd_ptr_gray settles in rq_sync after SYNC_STAGES edges. full, almost_full and wr_count reflect it at the next edge, SYNC_STAGES+1 edges after capture (3 with defaults).
- Simultaneous push and read-pointer update: both apply in one computation, so occupancy is unchanged.
- Wrap-around: after DEPTH pushes the address returns to 0 and the lap bit toggles. Full compares across the lap bit.
- overflow sets at the edge after the first wr_req with full = 1.

## Test plan
- Reset, then 16 consecutive pushes with rd_ptr_gray = 0 (defaults):
  - ram_wr_addr steps 0..15.
  - wr_ptr_gray follows 00000, 00001, 00011, 00010, …, 11000.
  - full rises at the 16th push edge; wr_count = 16.
  - almost_full rises at the 12th push edge.
- While full, hold wr_req = 1 for 3 cycles:
  - ram_wr_en stays 0 and wr_bin is unchanged.
  - overflow = 1 after the first edge and stays sticky.
  - ovf_clr pulse returns overflow to 0.
- From full, step rd_ptr_gray to 00001:
  - full falls and wr_count = 15 exactly 3 wr_clk edges later, not earlier.
- Push and read continuously for 40 entries, with rd_ptr_gray advanced Gray-legally from an unrelated clock:
  - Lap bit toggles at pushes 16 and 32.
  - No write is accepted while the true occupancy is 16.
  - wr_count never exceeds 16.
- Assert rst_n = 0 for 1 cycle after 7 pushes:
  - All outputs read 0 at the next edge.
  - The next push uses address 0.
- Parameter sweep ADDR_WIDTH = 1 and ALMOST_FULL_THRESH = 2:
  - full after 2 pushes, together with almost_full.
